// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_arb_pkg;

  localparam int OPCODE_W = 3;
  localparam int PERF_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            any_req
);

  localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

  logic [PW:0]   sum_s;
  logic [PW-1:0] cand_s;
  logic          hit_s;
  logic          found_s;

  // Scan from the pointer outward; the first hit blocks all later candidates.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    sum_s     = '0;
    cand_s    = '0;
    hit_s     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s         = {1'b0, rr_ptr} + (PW+1)'(k);
      cand_s        = (sum_s >= NREQ_W) ? PW'(sum_s - NREQ_W) : PW'(sum_s);
      hit_s         = req[cand_s] & ~found_s;
      grant[cand_s] = grant[cand_s] | hit_s;
      grant_idx     = hit_s ? cand_s : grant_idx;
      found_s       = found_s | hit_s;
    end
    any_req = found_s;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one external ALU among NREQ valid/ready requesters (IDLE -> EXEC -> RESP).
// Optional: define ALU_ARB_PERF_EN to add the saturating op_count output.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*N-1:0]        req_a,
  input  logic [NREQ*N-1:0]        req_b,
  input  logic [NREQ*OPCODE_W-1:0] req_opcode,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [N-1:0]             rsp_y,
  output logic [N-1:0]             alu_a,
  output logic [N-1:0]             alu_b,
  output logic [OPCODE_W-1:0]      alu_opcode,
  input  logic [N-1:0]             alu_y
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0]        op_count
`endif
);

  localparam int PW = $clog2(NREQ);

  arb_state_t            state_r, state_nx_s;
  logic [PW-1:0]         grant_r, rr_ptr_r, next_ptr_s;
  logic [N-1:0]          alu_a_r, alu_b_r, rsp_y_r;
  logic [OPCODE_W-1:0]   alu_op_r;
  logic [NREQ-1:0]       rsp_valid_r;
  logic [NREQ-1:0]       arb_grant_s;
  logic [PW-1:0]         arb_idx_s;
  logic                  any_req_s;
  logic [N-1:0]          sel_a_s, sel_b_s;
  logic [OPCODE_W-1:0]   sel_op_s;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_r),
    .grant     (arb_grant_s),
    .grant_idx (arb_idx_s),
    .any_req   (any_req_s)
  );

  // AND-OR mux of the winning requester's fields using the one-hot grant.
  always_comb begin
    sel_a_s  = '0;
    sel_b_s  = '0;
    sel_op_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a_s  = sel_a_s  | (req_a[i*N +: N] & {N{arb_grant_s[i]}});
      sel_b_s  = sel_b_s  | (req_b[i*N +: N] & {N{arb_grant_s[i]}});
      sel_op_s = sel_op_s | (req_opcode[i*OPCODE_W +: OPCODE_W] & {OPCODE_W{arb_grant_s[i]}});
    end
  end

  assign next_ptr_s = (arb_idx_s == PW'(NREQ-1)) ? '0 : arb_idx_s + PW'(1);

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_nx_s = EXEC;
        else           state_nx_s = IDLE;
      end
      EXEC:    state_nx_s = RESP;
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, operand latches, result capture and response pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      grant_r     <= '0;
      rr_ptr_r    <= '0;
      alu_a_r     <= '0;
      alu_b_r     <= '0;
      alu_op_r    <= '0;
      rsp_y_r     <= '0;
      rsp_valid_r <= '0;
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            alu_a_r  <= sel_a_s;
            alu_b_r  <= sel_b_s;
            alu_op_r <= sel_op_s;
            grant_r  <= arb_idx_s;
            rr_ptr_r <= next_ptr_s;
          end
          rsp_valid_r <= '0;
        end
        EXEC: begin
          rsp_y_r     <= alu_y;
          rsp_valid_r <= {{(NREQ-1){1'b0}}, 1'b1} << grant_r;
        end
        RESP:    rsp_valid_r <= '0;
        default: rsp_valid_r <= '0;
      endcase
    end
  end

  // Grants are only visible in IDLE and are forced low during reset.
  assign req_ready  = (rst_n && (state_r == IDLE)) ? arb_grant_s : '0;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_y      = rsp_y_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_opcode = alu_op_r;

`ifdef ALU_ARB_PERF_EN
  logic [PERF_W-1:0] op_count_r;

  // Completed-operation counter, saturating at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= '0;
    end else if ((state_r == RESP) && (op_count_r != {PERF_W{1'b1}})) begin
      op_count_r <= op_count_r + PERF_W'(1);
    end
  end

  assign op_count = op_count_r;
`endif

endmodule
